// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage: sequential stepping, stalls,
// branch/exception redirects and a fixed-length fetch bubble after each redirect.
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int                 STEP         = 4,
    parameter int                 FLUSH_CYCLES = 1,
    parameter int                 CNT_WIDTH    = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [WIDTH-1:0]     BranchTarget,
    input  logic                 Exception,
    output logic [WIDTH-1:0]     PCResult,
    output logic [WIDTH-1:0]     PCPlusStep,
    output logic                 FetchValid,
    output logic                 Misaligned,
    output logic [CNT_WIDTH-1:0] FetchCount
);

    typedef enum logic {RUN, FLUSH} state_t;

    // STEP is a power of two, so STEP-1 masks exactly the low log2(STEP) bits
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [7:0]       FLUSH_LOAD = 8'(FLUSH_CYCLES);

    state_t                 r_state;
    logic [7:0]             r_flushCnt;
    logic [WIDTH-1:0]       r_pc;
    logic                   r_misaligned;
    logic [CNT_WIDTH-1:0]   r_fetchCount;

    state_t                 w_nextState;
    logic [7:0]             w_nextFlushCnt;
    logic [WIDTH-1:0]       w_nextPc;
    logic                   w_nextMisaligned;
    logic                   w_targetMisaligned;
    logic                   w_countFetch;

    assign w_targetMisaligned = |(BranchTarget & ALIGN_MASK);
    assign w_countFetch = (r_state == RUN) && !Stall && !Exception && !BranchTaken;

    always_comb begin
        w_nextState      = r_state;
        w_nextFlushCnt   = r_flushCnt;
        w_nextPc         = r_pc;
        w_nextMisaligned = 1'b0;
        if (Exception) begin
            w_nextPc       = EXC_VECTOR;
            w_nextState    = FLUSH;
            w_nextFlushCnt = FLUSH_LOAD;
        end else if (BranchTaken && w_targetMisaligned) begin
            w_nextPc         = EXC_VECTOR;
            w_nextMisaligned = 1'b1;
            w_nextState      = FLUSH;
            w_nextFlushCnt   = FLUSH_LOAD;
        end else if (BranchTaken) begin
            w_nextPc       = BranchTarget;
            w_nextState    = FLUSH;
            w_nextFlushCnt = FLUSH_LOAD;
        end else if (r_state == FLUSH) begin
            w_nextFlushCnt = r_flushCnt - 8'd1;
            if (r_flushCnt == 8'd1) begin
                w_nextState = RUN;
            end
        end else if (!Stall) begin
            w_nextPc = r_pc + WIDTH'(STEP);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= RUN;
            r_flushCnt   <= 8'd0;
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
            r_fetchCount <= '0;
        end else begin
            r_state      <= w_nextState;
            r_flushCnt   <= w_nextFlushCnt;
            r_pc         <= w_nextPc;
            r_misaligned <= w_nextMisaligned;
            if (w_countFetch) begin
                r_fetchCount <= r_fetchCount + CNT_WIDTH'(1);
            end
        end
    end

    assign PCResult   = r_pc;
    assign PCPlusStep = r_pc + WIDTH'(STEP);
    assign FetchValid = (r_state == RUN);
    assign Misaligned = r_misaligned;
    assign FetchCount = r_fetchCount;

endmodule
